// File: rtl/timer_device_pkg.sv
// Shared constants and types for the bus-attached down-counting timer.
package timer_device_pkg;

  // Register index (Addr[3:2]) within the 12-byte window
  localparam logic [1:0] CTRL_IDX   = 2'd0;
  localparam logic [1:0] PRESET_IDX = 2'd1;
  localparam logic [1:0] COUNT_IDX  = 2'd2;

  // Mode encodings; 2 and 3 are reserved and act as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_device_if.sv
// Processor bus slice seen by the timer: PrAddr / PrWe / PrWD in, PrRD out.
interface timer_device_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_device.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers and one IRQ.
// Address decode, register file and FSM live together; the bus bridge is external.
module timer_device
  import timer_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic           clk,
  input  logic           reset,
  timer_device_if.slave  bus,
  output logic           IRQ
);

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  state_t      state;
  logic        irq_pend;

  logic        sel;
  logic [1:0]  idx;
  logic        wr;

  // Window decode; byte-lane bits Addr[1:0] never affect the register index
  assign sel = (bus.Addr >= BASE_ADDR) && (bus.Addr <= (BASE_ADDR + 32'hB));
  assign idx = bus.Addr[3:2];
  assign wr  = sel && bus.WE;

  // Interrupt is a pure function of registered state, so reset clears it without glitching
  assign IRQ = ctrl.im & irq_pend;

  // Combinational read mux; unselected addresses return zero for the external PrRD mux
  always_comb begin
    bus.Dout = '0;
    if (sel) begin
      case (idx)
        CTRL_IDX:   bus.Dout = {28'b0, ctrl};
        PRESET_IDX: bus.Dout = preset;
        COUNT_IDX:  bus.Dout = count;
        default:    bus.Dout = '0;
      endcase
    end
  end

  // Counter FSM plus register writes; bus writes come last so they win over FSM updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= IDLE;
      irq_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;
          end else if (count == 32'd0) begin
            state    <= INT;
            irq_pend <= 1'b1;
          end else begin
            // Only decrements when nonzero, so COUNT never wraps
            count <= count - 32'd1;
          end
        end
        INT: begin
          if (ctrl.mode == MODE_RELOAD) begin
            irq_pend <= 1'b0;
            state    <= LOAD;
          end else begin
            // One-shot (and reserved modes): stop, leave interrupt pending
            ctrl.en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr && (idx == CTRL_IDX)) begin
        ctrl     <= ctrl_t'(bus.Din[3:0]);
        irq_pend <= 1'b0;
      end
      if (wr && (idx == PRESET_IDX)) begin
        preset <= bus.Din;
      end
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: expected values go into a scoreboard queue
// when a read/IRQ probe is driven and are popped when the DUT output is sampled.
module tb_timer_device;

  logic clk;
  logic reset;
  logic IRQ;

  timer_device_if bus();

  timer_device #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  localparam logic [31:0] A_CTRL   = 32'h7F00;
  localparam logic [31:0] A_PRESET = 32'h7F04;
  localparam logic [31:0] A_COUNT  = 32'h7F08;

  // Pop the oldest expectation and compare against what the DUT shows now
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: got %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.Addr = addr;
    bus.WE   = 1'b0;
    exp_q.push_back(exp);
    #1;
    chk(tag, bus.Dout);
  endtask

  task automatic irq(input logic exp, input string tag);
    exp_q.push_back({31'b0, exp});
    #1;
    chk(tag, {31'b0, IRQ});
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Addr = addr;
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.Addr = '0;
    bus.Din  = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    @(negedge clk);
    rd(32'h0, 32'h0, "rst_unsel_dout");
    irq(1'b0, "rst_irq");
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_PRESET, 32'h0, "rst_preset");
    @(negedge clk);
    reset = 1'b1;
    step(1);
    rd(A_COUNT, 32'h0, "rst_count");

    // 1: reset mid-count, auto-reload, IM set
    wr(A_PRESET, 32'd100);
    wr(A_CTRL, 32'hB);
    step(5);
    rd(A_COUNT, 32'd97, "t1_count_running");
    #1 reset = 1'b0;
    irq(1'b0, "t1_irq_in_reset");
    rd(A_COUNT, 32'h0, "t1_count_in_reset");
    rd(A_CTRL, 32'h0, "t1_ctrl_in_reset");
    @(negedge clk);
    reset = 1'b1;
    step(3);
    rd(A_COUNT, 32'h0, "t1_count_after");
    rd(A_PRESET, 32'h0, "t1_preset_after");
    irq(1'b0, "t1_irq_after");

    // 2: one-shot, PRESET=3, IRQ level at E+6
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    step(5);
    irq(1'b0, "t2_irq_e5");
    step(1);
    irq(1'b1, "t2_irq_e6");
    rd(A_COUNT, 32'd0, "t2_count_e6");
    step(1);
    rd(A_CTRL, 32'h8, "t2_ctrl_en_cleared");
    irq(1'b1, "t2_irq_e7");
    step(3);
    irq(1'b1, "t2_irq_held");
    wr(A_CTRL, 32'h8);
    irq(1'b0, "t2_irq_cleared");
    rd(A_CTRL, 32'h8, "t2_ctrl_after_clr");

    // 3: auto-reload, PRESET=2, one-cycle pulse every 5 cycles
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    step(2);
    for (int p = 0; p < 2; p++) begin
      rd(A_COUNT, 32'd2, "t3_count2");
      irq(1'b0, "t3_irq_c2");
      step(1);
      rd(A_COUNT, 32'd1, "t3_count1");
      step(1);
      rd(A_COUNT, 32'd0, "t3_count0");
      irq(1'b0, "t3_irq_c0");
      step(1);
      irq(1'b1, "t3_irq_pulse");
      step(1);
      irq(1'b0, "t3_irq_after_pulse");
      step(1);
    end
    wr(A_CTRL, 32'h0);
    step(4);
    irq(1'b0, "t3_irq_stopped");

    // 4: PRESET=0, IM=0 -> INT at E+3, IRQ masked, Enable self-clears
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h1);
    step(3);
    irq(1'b0, "t4_irq_masked");
    rd(A_CTRL, 32'h1, "t4_ctrl_at_int");
    step(1);
    rd(A_CTRL, 32'h0, "t4_ctrl_cleared");
    irq(1'b0, "t4_irq_after");

    // 5: writes to COUNT ignored, PRESET change deferred, disable freezes
    wr(A_PRESET, 32'd50);
    wr(A_CTRL, 32'h1);
    step(2);
    rd(A_COUNT, 32'd50, "t5_loaded");
    step(3);
    rd(A_COUNT, 32'd47, "t5_count47");
    wr(A_COUNT, 32'd7);
    rd(A_COUNT, 32'd46, "t5_count_wr_ignored");
    wr(A_PRESET, 32'd5);
    rd(A_COUNT, 32'd45, "t5_preset_no_effect");
    rd(A_PRESET, 32'd5, "t5_preset_rb");
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, 32'd44, "t5_count_at_disable");
    step(1);
    rd(A_COUNT, 32'd44, "t5_frozen1");
    step(3);
    rd(A_COUNT, 32'd44, "t5_frozen2");
    wr(A_CTRL, 32'h1);
    step(2);
    rd(A_COUNT, 32'd5, "t5_reload_new_preset");
    wr(A_CTRL, 32'h0);
    step(3);

    // 6: out-of-window accesses, byte-address aliasing
    wr(32'h7F0C, 32'hFFFF_FFFF);
    rd(32'h7F0C, 32'h0, "t6_dout_7f0c");
    wr(32'h7EFC, 32'hFFFF_FFFF);
    rd(32'h7EFC, 32'h0, "t6_dout_7efc");
    rd(A_CTRL, 32'h0, "t6_ctrl_untouched");
    rd(A_PRESET, 32'd5, "t6_preset_untouched");
    wr(32'h7F01, 32'h9);
    rd(A_CTRL, 32'h9, "t6_ctrl_via_7f01");
    rd(32'h7F03, 32'h9, "t6_ctrl_rd_7f03");
    wr(A_CTRL, 32'h0);
    step(3);

    // PRESET all-ones counts down without overflow
    wr(A_PRESET, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    step(2);
    rd(A_COUNT, 32'hFFFF_FFFF, "max_loaded");
    step(1);
    rd(A_COUNT, 32'hFFFF_FFFE, "max_dec");
    wr(A_CTRL, 32'h0);
    step(3);

    // Reset while a one-shot IRQ is asserted drops it immediately
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(3);
    irq(1'b1, "rst2_irq_high");
    #1 reset = 1'b0;
    irq(1'b0, "rst2_irq_dropped");
    rd(A_CTRL, 32'h0, "rst2_ctrl");
    @(negedge clk);
    reset = 1'b1;
    step(2);
    irq(1'b0, "rst2_irq_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
